ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
//  Consumer of the decoder's control bundle. Carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
//  - Bundle fields: RegDs, Branch, MRead, MtoR, AOp, MWrite, ALUsrc, Urw.
//  - Detects load-use hazards and stalls for them; flushes on a taken BEQ resolved in MEM.
//  - Sits between the control decoder (ID) and the EX/MEM/WB datapath.
// PARAMETERS
//  REG_W   5   register-number width (rs/rt/rd, write destination)
//  AOP_W   3   ALU-op field width
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  id_RegDs     in   1      decoded control, ID stage
//  id_Branch    in   1      |
//  id_MRead     in   1      |
//  id_MtoR      in   1      |
//  id_AOp       in   AOP_W  |
//  id_MWrite    in   1      |
//  id_ALUsrc    in   1      |
//  id_Urw       in   1      decoded control, ID stage
//  id_rs,id_rt,id_rd in REG_W  ID-stage register fields
//  ex_zero      in   1      ALU zero flag, EX stage (registered into EX/MEM)
//  ex_RegDs,ex_AOp,ex_ALUsrc  out  1/AOP_W/1  EX controls from ID/EX
//  ex_rt,ex_rd  out  REG_W  EX-stage register fields
//  mem_MRead,mem_MWrite  out 1   memory controls from EX/MEM
//  mem_pcsrc    out  1      Branch&zero in MEM: take branch
//  wb_MtoR,wb_Urw  out  1   writeback controls from MEM/WB
//  wb_wreg      out  REG_W  writeback destination
//  stall        out  1      hold PC and IF/ID this cycle
//  flush        out  1      squash IF/ID this cycle (equals mem_pcsrc)
// BEHAVIOUR
//  Reset:
//  - All pipeline registers clear to 0 (bubble) on the rst edge.
//  - Every registered output is 0; stall=0; flush=0.
//  - rst mid-operation discards all in-flight bundles in the same cycle.
//  Latency: one cycle per stage.
//  - ID bundle appears on ex_* at N+1, mem_* at N+2, wb_* at N+3.
//  Bubble and X handling:
//  - A bubble is the all-zero bundle. Urw, MWrite, MRead and Branch are all 0, so a bubble has no side effects.
//  - X on any id_* input is captured as 0 for Urw, MWrite, MRead and Branch. X from an unknown opcode must never write state.
//  Destination select:
//  - EX/MEM wreg = ex_RegDs ? ex_rd : ex_rt, captured at the EX->MEM edge.
//  - Carried unchanged into MEM/WB.
//  Load-use hazard (combinational):
//  - stall = ex_MRead & ((ex_rt==id_rs) | (ex_rt==id_rt)) & ex_rt!=0.
//  - While stall: ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
//  - stall lasts exactly one cycle per load-use pair.
//  Branch (combinational):
//  - mem_pcsrc = mem_Branch & mem_zero; flush = mem_pcsrc.
//  - While flush: ID/EX and EX/MEM load bubbles. MEM/WB still advances with the BEQ bundle, whose Urw is 0.
//  Simultaneous stall and flush: flush wins. stall is forced to 0 and both bubbles are inserted.
//  Register 0: writes to wreg=0 are not suppressed here; the register file ignores them.
//  Fixed pipeline stages: ID, EX, MEM, WB; no state machine beyond the stage registers.
// STRUCTURE
//  Shared package ctrl_pkg:
//  - AOp encodings: LW 000, BEQ 001, R 010, ADDI 011, SLTI 100, ANDI 101, ORI 110, SW 111.
//  - Opcode constants.
//  - Bundle field widths and the BUBBLE constant.
//  One sub-module, hazard_detect: purely combinational; produces stall and flush.
//  Stage registers stay inline in ctrl_pipe.
// TESTING
//  1 Reset: rst=1 for 2 cycles with random id_* -> all outputs 0. rst mid-stream -> wb_Urw=0 on the next cycle.
//  2 Propagation: ADDI bundle (AOp=011, ALUsrc=1, Urw=1, RegDs=0, rt=5) at cycle 0
//    -> ex_AOp=011 at 1; wb_Urw=1 and wb_wreg=5 at 3.
//  3 R-type dest: RegDs=1, rd=9, rt=4 -> wb_wreg=9. SW (Urw=0) -> wb_Urw=0, mem_MWrite=1 at N+2.
//  4 Load-use: LW rt=8, then ADD rs=8 -> stall=1 for exactly one cycle; ex_* all 0 next cycle; ADD reaches EX one cycle late.
//    Same sequence with rt=0 -> no stall.
//  5 Branch: BEQ with ex_zero=1 -> mem_pcsrc=flush=1 at N+2; following two bundles never reach mem/wb.
//    ex_zero=0 -> no flush.
//  6 Stall and flush same cycle: LW/use pair behind a taken BEQ -> flush=1, stall=0, bubbles in ID/EX and EX/MEM.
//    X on id_Urw -> wb_Urw=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control pipeline.
//  - ALU-op (AOp) encodings and MIPS-style opcode constants.
//  - Bundle field widths, the packed single-bit control flags and the
//    BUBBLE constant (the all-zero, side-effect-free bundle).
//  - known_one(): treats an unknown/undriven control bit as 0 so that an
//    undecodable opcode can never enable a state write.
package ctrl_pkg;

    localparam int CTRL_REG_W = 5;
    localparam int CTRL_AOP_W = 3;

    typedef enum logic [CTRL_AOP_W-1:0] {
        AOP_LW   = 3'b000,
        AOP_BEQ  = 3'b001,
        AOP_R    = 3'b010,
        AOP_ADDI = 3'b011,
        AOP_SLTI = 3'b100,
        AOP_ANDI = 3'b101,
        AOP_ORI  = 3'b110,
        AOP_SW   = 3'b111
    } aop_e;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_SLTI = 6'h0a;
    localparam logic [5:0] OPC_ANDI = 6'h0c;
    localparam logic [5:0] OPC_ORI  = 6'h0d;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2b;

    typedef struct packed {
        logic reg_ds;
        logic branch;
        logic mread;
        logic mtor;
        logic mwrite;
        logic alusrc;
        logic urw;
    } flags_t;

    localparam flags_t BUBBLE = '0;

    // Only a definite 1 enables a side effect; X/Z collapse to 0.
    function automatic logic known_one(input logic b);
        return (b === 1'b1);
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_detect.sv
// hazard_detect: purely combinational stall/flush generation.
//  Ports:
//   ex_MRead, ex_rt     load in EX and its destination register
//   id_rs, id_rt        source registers of the instruction in ID
//   mem_Branch, mem_zero  BEQ in MEM and its registered ALU zero flag
//   stall               hold PC and IF/ID, bubble into ID/EX
//   flush               taken branch: squash IF/ID, ID/EX and EX/MEM
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_MRead,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             mem_Branch,
    input  logic             mem_zero,
    output logic             stall,
    output logic             flush
);

    logic load_use;

    // Register 0 never carries a real dependency, so it cannot cause a stall.
    assign load_use = ex_MRead && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign flush    = mem_Branch && mem_zero;
    // A taken branch discards the dependent pair anyway; flush wins.
    assign stall    = load_use && !flush;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control bundle through the ID/EX, EX/MEM
// and MEM/WB pipeline registers, inserting bubbles for load-use stalls and
// taken-branch flushes.
//  Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_*                     decoded control bundle and register fields (ID)
//   ex_zero                  ALU zero flag from EX, registered into EX/MEM
//   ex_RegDs/AOp/ALUsrc/rt/rd  EX-stage controls from ID/EX
//   mem_MRead/MWrite/pcsrc   MEM-stage controls from EX/MEM
//   wb_MtoR/Urw/wreg         WB-stage controls from MEM/WB
//   stall, flush             hazard outputs (flush equals mem_pcsrc)
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int AOP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_RegDs,
    input  logic             id_Branch,
    input  logic             id_MRead,
    input  logic             id_MtoR,
    input  logic [AOP_W-1:0] id_AOp,
    input  logic             id_MWrite,
    input  logic             id_ALUsrc,
    input  logic             id_Urw,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_zero,
    output logic             ex_RegDs,
    output logic [AOP_W-1:0] ex_AOp,
    output logic             ex_ALUsrc,
    output logic [REG_W-1:0] ex_rt,
    output logic [REG_W-1:0] ex_rd,
    output logic             mem_MRead,
    output logic             mem_MWrite,
    output logic             mem_pcsrc,
    output logic             wb_MtoR,
    output logic             wb_Urw,
    output logic [REG_W-1:0] wb_wreg,
    output logic             stall,
    output logic             flush
);

    // ID/EX
    flags_t             idex_flags_q, idex_flags_d;
    logic [AOP_W-1:0]   idex_aop_q, idex_aop_d;
    logic [REG_W-1:0]   idex_rt_q, idex_rt_d;
    logic [REG_W-1:0]   idex_rd_q, idex_rd_d;
    // EX/MEM
    logic               exmem_branch_q, exmem_branch_d;
    logic               exmem_mread_q, exmem_mread_d;
    logic               exmem_mwrite_q, exmem_mwrite_d;
    logic               exmem_mtor_q, exmem_mtor_d;
    logic               exmem_urw_q, exmem_urw_d;
    logic               exmem_zero_q, exmem_zero_d;
    logic [REG_W-1:0]   exmem_wreg_q, exmem_wreg_d;
    // MEM/WB
    logic               memwb_mtor_q, memwb_mtor_d;
    logic               memwb_urw_q, memwb_urw_d;
    logic [REG_W-1:0]   memwb_wreg_q, memwb_wreg_d;

    flags_t             id_flags;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_MRead   (idex_flags_q.mread),
        .ex_rt      (idex_rt_q),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .mem_Branch (exmem_branch_q),
        .mem_zero   (exmem_zero_q),
        .stall      (stall),
        .flush      (flush)
    );

    always_comb begin
        // Side-effect bits are sanitised so an unknown opcode behaves as a bubble.
        id_flags.reg_ds = id_RegDs;
        id_flags.branch = known_one(id_Branch);
        id_flags.mread  = known_one(id_MRead);
        id_flags.mtor   = id_MtoR;
        id_flags.mwrite = known_one(id_MWrite);
        id_flags.alusrc = id_ALUsrc;
        id_flags.urw    = known_one(id_Urw);

        if (flush || stall) begin
            idex_flags_d = BUBBLE;
            idex_aop_d   = '0;
            idex_rt_d    = '0;
            idex_rd_d    = '0;
        end else begin
            idex_flags_d = id_flags;
            idex_aop_d   = id_AOp;
            idex_rt_d    = id_rt;
            idex_rd_d    = id_rd;
        end

        // A stall only bubbles ID/EX; the instruction in EX still advances.
        if (flush) begin
            exmem_branch_d = 1'b0;
            exmem_mread_d  = 1'b0;
            exmem_mwrite_d = 1'b0;
            exmem_mtor_d   = 1'b0;
            exmem_urw_d    = 1'b0;
            exmem_zero_d   = 1'b0;
            exmem_wreg_d   = '0;
        end else begin
            exmem_branch_d = idex_flags_q.branch;
            exmem_mread_d  = idex_flags_q.mread;
            exmem_mwrite_d = idex_flags_q.mwrite;
            exmem_mtor_d   = idex_flags_q.mtor;
            exmem_urw_d    = idex_flags_q.urw;
            exmem_zero_d   = ex_zero;
            exmem_wreg_d   = idex_flags_q.reg_ds ? idex_rd_q : idex_rt_q;
        end

        // MEM/WB always advances; a flushing BEQ itself has Urw=0.
        memwb_mtor_d = exmem_mtor_q;
        memwb_urw_d  = exmem_urw_q;
        memwb_wreg_d = exmem_wreg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_flags_q   <= BUBBLE;
            idex_aop_q     <= '0;
            idex_rt_q      <= '0;
            idex_rd_q      <= '0;
            exmem_branch_q <= 1'b0;
            exmem_mread_q  <= 1'b0;
            exmem_mwrite_q <= 1'b0;
            exmem_mtor_q   <= 1'b0;
            exmem_urw_q    <= 1'b0;
            exmem_zero_q   <= 1'b0;
            exmem_wreg_q   <= '0;
            memwb_mtor_q   <= 1'b0;
            memwb_urw_q    <= 1'b0;
            memwb_wreg_q   <= '0;
        end else begin
            idex_flags_q   <= idex_flags_d;
            idex_aop_q     <= idex_aop_d;
            idex_rt_q      <= idex_rt_d;
            idex_rd_q      <= idex_rd_d;
            exmem_branch_q <= exmem_branch_d;
            exmem_mread_q  <= exmem_mread_d;
            exmem_mwrite_q <= exmem_mwrite_d;
            exmem_mtor_q   <= exmem_mtor_d;
            exmem_urw_q    <= exmem_urw_d;
            exmem_zero_q   <= exmem_zero_d;
            exmem_wreg_q   <= exmem_wreg_d;
            memwb_mtor_q   <= memwb_mtor_d;
            memwb_urw_q    <= memwb_urw_d;
            memwb_wreg_q   <= memwb_wreg_d;
        end
    end

    assign ex_RegDs   = idex_flags_q.reg_ds;
    assign ex_AOp     = idex_aop_q;
    assign ex_ALUsrc  = idex_flags_q.alusrc;
    assign ex_rt      = idex_rt_q;
    assign ex_rd      = idex_rd_q;
    assign mem_MRead  = exmem_mread_q;
    assign mem_MWrite = exmem_mwrite_q;
    assign mem_pcsrc  = flush;
    assign wb_MtoR    = memwb_mtor_q;
    assign wb_Urw     = memwb_urw_q;
    assign wb_wreg    = memwb_wreg_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed, table-driven check of ctrl_pipe, followed by
// hand-written sequences for stall, flush, reset and X corner cases.
module tb_ctrl_pipe;

    logic       clk;
    logic       rst;
    logic       id_RegDs, id_Branch, id_MRead, id_MtoR;
    logic [2:0] id_AOp;
    logic       id_MWrite, id_ALUsrc, id_Urw;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_zero;
    logic       ex_RegDs;
    logic [2:0] ex_AOp;
    logic       ex_ALUsrc;
    logic [4:0] ex_rt, ex_rd;
    logic       mem_MRead, mem_MWrite, mem_pcsrc;
    logic       wb_MtoR, wb_Urw;
    logic [4:0] wb_wreg;
    logic       stall, flush;

    int checks   = 0;
    int failures = 0;

    ctrl_pipe #(.REG_W(5), .AOP_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_RegDs   (id_RegDs),
        .id_Branch  (id_Branch),
        .id_MRead   (id_MRead),
        .id_MtoR    (id_MtoR),
        .id_AOp     (id_AOp),
        .id_MWrite  (id_MWrite),
        .id_ALUsrc  (id_ALUsrc),
        .id_Urw     (id_Urw),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .ex_zero    (ex_zero),
        .ex_RegDs   (ex_RegDs),
        .ex_AOp     (ex_AOp),
        .ex_ALUsrc  (ex_ALUsrc),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .mem_MRead  (mem_MRead),
        .mem_MWrite (mem_MWrite),
        .mem_pcsrc  (mem_pcsrc),
        .wb_MtoR    (wb_MtoR),
        .wb_Urw     (wb_Urw),
        .wb_wreg    (wb_wreg),
        .stall      (stall),
        .flush      (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       reg_ds, branch, mread, mtor;
        logic [2:0] aop;
        logic       mwrite, alusrc, urw;
        logic [4:0] rs, rt, rd;
    } bund_t;

    typedef struct {
        string       name;
        bund_t       b;
        logic [14:0] exp_ex;   // {RegDs, AOp, ALUsrc, rt, rd} at N+1
        logic [1:0]  exp_mem;  // {MRead, MWrite} at N+2
        logic [6:0]  exp_wb;   // {MtoR, Urw, wreg} at N+3
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    function automatic bund_t mkb(input logic rds, input logic br, input logic mr, input logic m2r,
                                  input logic [2:0] aop, input logic mw, input logic als,
                                  input logic urw, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd);
        bund_t b;
        b.reg_ds = rds; b.branch = br; b.mread = mr; b.mtor = m2r;
        b.aop = aop; b.mwrite = mw; b.alusrc = als; b.urw = urw;
        b.rs = rs; b.rt = rt; b.rd = rd;
        return b;
    endfunction

    task automatic drive(input bund_t b);
        id_RegDs = b.reg_ds; id_Branch = b.branch; id_MRead = b.mread; id_MtoR = b.mtor;
        id_AOp = b.aop; id_MWrite = b.mwrite; id_ALUsrc = b.alusrc; id_Urw = b.urw;
        id_rs = b.rs; id_rt = b.rt; id_rd = b.rd;
    endtask

    task automatic drive_bubble();
        drive(mkb(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0));
    endtask

    task automatic drive_random();
        id_RegDs = 1'($urandom); id_Branch = 1'($urandom); id_MRead = 1'($urandom);
        id_MtoR = 1'($urandom); id_AOp = 3'($urandom); id_MWrite = 1'($urandom);
        id_ALUsrc = 1'($urandom); id_Urw = 1'($urandom);
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        ex_zero = 1'($urandom);
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] ex_vec();
        return {ex_RegDs, ex_AOp, ex_ALUsrc, ex_rt, ex_rd};
    endfunction

    function automatic logic [6:0] wb_vec();
        return {wb_MtoR, wb_Urw, wb_wreg};
    endfunction

    function automatic logic [26:0] all_out();
        return {ex_RegDs, ex_AOp, ex_ALUsrc, ex_rt, ex_rd, mem_MRead, mem_MWrite, mem_pcsrc,
                wb_MtoR, wb_Urw, wb_wreg, stall, flush};
    endfunction

    bund_t addi_b, lw_b, lw0_b, add_b, add0_b, beq_b, x1_b, x2_b;

    initial begin
        // Hand-computed vectors: name, bundle {RegDs,Br,MRd,MtoR,AOp,MWr,ALUsrc,Urw,rs,rt,rd},
        // expected EX, MEM, WB.
        vecs[0] = '{"ADDI", mkb(1'b0,1'b0,1'b0,1'b0,3'd3,1'b0,1'b1,1'b1,5'd1,5'd5,5'd0),
                    {1'b0,3'd3,1'b1,5'd5,5'd0}, 2'b00, {1'b0,1'b1,5'd5}};
        vecs[1] = '{"R",    mkb(1'b1,1'b0,1'b0,1'b0,3'd2,1'b0,1'b0,1'b1,5'd2,5'd4,5'd9),
                    {1'b1,3'd2,1'b0,5'd4,5'd9}, 2'b00, {1'b0,1'b1,5'd9}};
        vecs[2] = '{"SW",   mkb(1'b0,1'b0,1'b0,1'b0,3'd7,1'b1,1'b1,1'b0,5'd1,5'd6,5'd3),
                    {1'b0,3'd7,1'b1,5'd6,5'd3}, 2'b01, {1'b0,1'b0,5'd6}};
        vecs[3] = '{"LW",   mkb(1'b0,1'b0,1'b1,1'b1,3'd0,1'b0,1'b1,1'b1,5'd3,5'd7,5'd0),
                    {1'b0,3'd0,1'b1,5'd7,5'd0}, 2'b10, {1'b1,1'b1,5'd7}};
        vecs[4] = '{"ORI0", mkb(1'b0,1'b0,1'b0,1'b0,3'd6,1'b0,1'b1,1'b1,5'd4,5'd0,5'd0),
                    {1'b0,3'd6,1'b1,5'd0,5'd0}, 2'b00, {1'b0,1'b1,5'd0}};
        vecs[5] = '{"BEQnt",mkb(1'b0,1'b1,1'b0,1'b0,3'd1,1'b0,1'b0,1'b0,5'd1,5'd2,5'd0),
                    {1'b0,3'd1,1'b0,5'd2,5'd0}, 2'b00, {1'b0,1'b0,5'd2}};

        addi_b = mkb(1'b0,1'b0,1'b0,1'b0,3'd3,1'b0,1'b1,1'b1,5'd1,5'd5,5'd0);
        lw_b   = mkb(1'b0,1'b0,1'b1,1'b1,3'd0,1'b0,1'b1,1'b1,5'd1,5'd8,5'd0);
        lw0_b  = mkb(1'b0,1'b0,1'b1,1'b1,3'd0,1'b0,1'b1,1'b1,5'd1,5'd0,5'd0);
        add_b  = mkb(1'b1,1'b0,1'b0,1'b0,3'd2,1'b0,1'b0,1'b1,5'd8,5'd3,5'd10);
        add0_b = mkb(1'b1,1'b0,1'b0,1'b0,3'd2,1'b0,1'b0,1'b1,5'd0,5'd3,5'd10);
        beq_b  = mkb(1'b0,1'b1,1'b0,1'b0,3'd1,1'b0,1'b0,1'b0,5'd1,5'd1,5'd0);
        x1_b   = mkb(1'b0,1'b0,1'b0,1'b0,3'd3,1'b0,1'b1,1'b1,5'd2,5'd11,5'd0);
        x2_b   = mkb(1'b0,1'b0,1'b0,1'b0,3'd7,1'b1,1'b1,1'b0,5'd2,5'd12,5'd0);

        // ---- Reset with random inputs ----
        rst = 1'b1;
        drive_random();
        tick();
        check("reset_c1_all", 32'(all_out()), 32'd0);
        drive_random();
        tick();
        check("reset_c2_all", 32'(all_out()), 32'd0);
        $display("txn reset: 2 cycles with random inputs");
        rst = 1'b0;
        ex_zero = 1'b0;
        drive_bubble();
        tick();

        // ---- Table-driven single-bundle propagation ----
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].b);
            tick();
            check({vecs[i].name, "_ex"}, 32'(ex_vec()), 32'(vecs[i].exp_ex));
            drive_bubble();
            ex_zero = 1'b0;
            #1;
            check({vecs[i].name, "_stall"}, 32'(stall), 32'd0);
            tick();
            check({vecs[i].name, "_mem"}, 32'({mem_MRead, mem_MWrite}), 32'(vecs[i].exp_mem));
            check({vecs[i].name, "_pcsrc"}, 32'(mem_pcsrc), 32'd0);
            tick();
            check({vecs[i].name, "_wb"}, 32'(wb_vec()), 32'(vecs[i].exp_wb));
            $display("txn %s: ex=0x%0h mem=0x%0h wb=0x%0h", vecs[i].name,
                     ex_vec(), {mem_MRead, mem_MWrite}, wb_vec());
        end

        // ---- Reset mid-stream discards in-flight ADDI ----
        drive(addi_b);
        tick();
        drive_bubble();
        tick();
        check("midrst_mem_urw_pre", 32'(dut.exmem_urw_q), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_wb_urw", 32'(wb_Urw), 32'd0);
        check("midrst_all", 32'(all_out()), 32'd0);
        rst = 1'b0;
        $display("txn midstream reset");

        // ---- Load-use: LW rt=8 then ADD rs=8 ----
        drive(lw_b);
        tick();
        drive(add_b);
        #1;
        check("lu_stall_on", 32'(stall), 32'd1);
        tick();
        check("lu_ex_bubble", 32'(ex_vec()), 32'd0);
        #1;
        check("lu_stall_off", 32'(stall), 32'd0);
        tick();
        check("lu_add_ex", 32'(ex_vec()), 32'({1'b1, 3'd2, 1'b0, 5'd3, 5'd10}));
        check("lu_lw_wb", 32'(wb_vec()), 32'({1'b1, 1'b1, 5'd8}));
        drive_bubble();
        tick();
        tick();
        check("lu_add_wb", 32'(wb_vec()), 32'({1'b0, 1'b1, 5'd10}));
        $display("txn load-use rt=8");

        // ---- Same with rt=0: no stall ----
        drive(lw0_b);
        tick();
        drive(add0_b);
        #1;
        check("lu0_no_stall", 32'(stall), 32'd0);
        tick();
        check("lu0_add_ex", 32'(ex_vec()), 32'({1'b1, 3'd2, 1'b0, 5'd3, 5'd10}));
        drive_bubble();
        tick();
        tick();
        tick();
        $display("txn load-use rt=0");

        // ---- Taken BEQ: following two bundles never reach MEM/WB ----
        drive(beq_b);
        tick();
        ex_zero = 1'b1;
        drive(x1_b);
        tick();
        ex_zero = 1'b0;
        drive(x2_b);
        #1;
        check("br_pcsrc", 32'(mem_pcsrc), 32'd1);
        check("br_flush", 32'(flush), 32'd1);
        tick();
        drive_bubble();
        check("br_ex_bubble", 32'(ex_vec()), 32'd0);
        check("br_mem_bubble", 32'({mem_MRead, mem_MWrite, mem_pcsrc}), 32'd0);
        check("br_wb_beq", 32'(wb_vec()), 32'({1'b0, 1'b0, 5'd1}));
        tick();
        check("br_x1_absent", 32'(wb_Urw), 32'd0);
        tick();
        check("br_x2_absent", 32'({wb_Urw, mem_MWrite}), 32'd0);
        tick();
        $display("txn taken beq");

        // ---- Not-taken BEQ: X1 proceeds to WB ----
        drive(beq_b);
        tick();
        ex_zero = 1'b0;
        drive(x1_b);
        tick();
        drive_bubble();
        #1;
        check("brnt_flush", 32'(flush), 32'd0);
        tick();
        tick();
        check("brnt_x1_wb", 32'(wb_vec()), 32'({1'b0, 1'b1, 5'd11}));
        $display("txn not-taken beq");

        // ---- Load-use pair behind a taken BEQ: flush wins ----
        drive(beq_b);
        tick();
        ex_zero = 1'b1;
        drive(lw_b);
        tick();
        ex_zero = 1'b0;
        drive(add_b);
        #1;
        check("sf_flush", 32'(flush), 32'd1);
        check("sf_stall", 32'(stall), 32'd0);
        tick();
        drive_bubble();
        check("sf_ex_bubble", 32'(ex_vec()), 32'd0);
        check("sf_mem_bubble", 32'(mem_MRead), 32'd0);
        tick();
        tick();
        $display("txn stall+flush");

        // ---- X on id_Urw / id_MWrite must not write state ----
        drive(addi_b);
        id_Urw = 1'bx;
        id_MWrite = 1'bx;
        tick();
        drive_bubble();
        tick();
        check("x_mem_mwrite", 32'(mem_MWrite), 32'd0);
        tick();
        check("x_wb_urw", 32'(wb_Urw), 32'd0);
        $display("txn X on Urw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
